// File: rtl/adder_pipe_pkg.sv
// Shared constants and result type for the 8-bit, 4-stage adder pipeline and its collector.
package adder_pipe_pkg;

    localparam int ADDER_W   = 8;
    localparam int ADDER_LAT = 4;

    typedef struct packed {
        logic               cout;
        logic [ADDER_W-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; dout shows the head whenever the FIFO is non-empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;
    // Gating the head keeps dout at zero while empty instead of exposing stale storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adder_result_collector.sv
// Tracks live slots of an unreset adder pipeline, captures their results into a FIFO and
// issues credits so the adder never produces more results than the FIFO can hold.
module adder_result_collector
    import adder_pipe_pkg::*;
#(
    parameter int DATA_W  = ADDER_W,
    parameter int LATENCY = ADDER_LAT,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      sum_in,
    input  logic                   cout_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_sum,
    output logic                   out_cout,
    output logic [$clog2(DEPTH):0] out_count,
    output logic                   proto_err
);

    localparam int SUM_W = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] vsr;
    logic [SUM_W-1:0]   inflight;
    logic [SUM_W-1:0]   credit_used;
    logic               accept;
    logic               fifo_empty;
    logic               fifo_full;
    logic [DATA_W:0]    fifo_dout;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SUM_W'(vsr[i]);
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready and out_valid depend only on registered state, never on the same-cycle partner.
    assign credit_used = SUM_W'(out_count) + inflight;
    assign in_ready    = ~fifo_full & (credit_used < SUM_W'(DEPTH));
    assign accept      = in_valid & in_ready;
    assign out_valid   = ~fifo_empty;
    assign {out_cout, out_sum} = fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr       <= '0;
            proto_err <= 1'b0;
        end else begin
            vsr       <= {vsr[LATENCY-2:0], accept};
            proto_err <= proto_err | (in_valid & ~in_ready);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vsr[LATENCY-1]),
        .din   ({cout_in, sum_in}),
        .pop   (out_valid & out_ready),
        .dout  (fifo_dout),
        .count (out_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector fed by a behavioural 4-stage unreset adder pipeline.
module tb_adder_result_collector;
    import adder_pipe_pkg::*;

    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sum_in;
    logic             cout_in;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic             out_cout;
    logic [3:0]       out_count;
    logic             proto_err;

    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             op_cin;
    add_res_t         apipe [ADDER_LAT];

    logic [8:0]       exp_q [$];
    int               n_vec;
    int               n_err;
    int               max_count;
    int               accepted;

    adder_result_collector #(
        .DATA_W  (8),
        .LATENCY (4),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_count (out_count),
        .proto_err (proto_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // behavioural adder: no reset, 4 register stages
    always_ff @(posedge clk) begin
        apipe[0] <= add_res_t'({1'b0, op_a} + {1'b0, op_b} + 9'(op_cin));
        for (int i = 1; i < ADDER_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign sum_in  = apipe[ADDER_LAT-1].sum;
    assign cout_in = apipe[ADDER_LAT-1].cout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks: inputs change 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic cin);
        op_a   = a;
        op_b   = b;
        op_cin = cin;
    endtask

    // scoreboard: record accepted issues, compare every pop, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (32'(out_count) > max_count) max_count = 32'(out_count);
            if (in_valid && in_ready)
                exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + 9'(op_cin));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_pop", 32'(1), 32'(0));
                else check("sb_result", 32'({out_cout, out_sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        max_count = 0;
        accepted  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops(8'd0, 8'd0, 1'b0);

        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_proto_err", 32'(proto_err), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_sum",   32'(out_sum),   32'(0));
        check("rst_out_cout",  32'(out_cout),  32'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // single issue 3+5
        out_ready = 1'b1;
        set_ops(8'd3, 8'd5, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("single_early", 32'(out_valid), 32'(0));
        tick();
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_sum",   32'(out_sum),   32'(8));
        check("single_cout",  32'(out_cout),  32'(0));
        tick();
        check("single_once",  32'(out_valid), 32'(0));

        // stream of 50 back-to-back issues
        for (int i = 0; i < 50; i++) begin
            set_ops(8'(i), 8'(10 + i), 1'b0);
            in_valid = 1'b1;
            check("stream_in_ready", 32'(in_ready), 32'(1));
            tick();
            if (i >= 4) check("stream_no_gap", 32'(out_valid), 32'(1));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_tail", 32'(out_valid), 32'(1));
        end
        tick();
        check("stream_done", 32'(out_valid), 32'(0));

        // wrap: 200 + 100 + 1 = 0x12D
        set_ops(8'd200, 8'd100, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("wrap_valid", 32'(out_valid), 32'(1));
        check("wrap_sum",   32'(out_sum),   32'h2D);
        check("wrap_cout",  32'(out_cout),  32'(1));
        tick();

        // backpressure: keep offering while credit is available
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_ops(8'(i * 7), 8'(i * 3 + 1), 1'b0);
            in_valid = in_ready;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted",  32'(accepted),  32'(8));
        check("bp_count",     32'(out_count), 32'(8));
        check("bp_in_ready",  32'(in_ready),  32'(0));
        check("bp_proto_err", 32'(proto_err), 32'(0));
        check("bp_head_sum",  32'(out_sum),   32'(1));

        // protocol violation while out of credit
        set_ops(8'hAA, 8'h01, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("perr_set", 32'(proto_err), 32'(1));
        repeat (6) tick();
        check("perr_count", 32'(out_count), 32'(8));
        check("perr_sticky", 32'(proto_err), 32'(1));

        // drain
        out_ready = 1'b1;
        tick();
        check("drain_in_ready", 32'(in_ready), 32'(1));
        repeat (8) tick();
        check("drain_empty",  32'(out_valid),     32'(0));
        check("drain_count",  32'(out_count),     32'(0));
        check("drain_sb",     32'(exp_q.size()),  32'(0));
        check("drain_sticky", 32'(proto_err),     32'(1));

        // reset with 3 in flight and 2 queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ops(8'(20 + i), 8'd1, 1'b0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_count", 32'(out_count), 32'(2));
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_count", 32'(out_count), 32'(0));
        check("mid_rst_ready", 32'(in_ready),  32'(1));
        check("mid_rst_perr",  32'(proto_err), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_idle", 32'(out_valid), 32'(0));
        end

        check("max_count", 32'(max_count <= DEPTH), 32'(1));
        check("final_sb",  32'(exp_q.size()),        32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
